uart_mmio_slave: RTL and testbench



---
 rtl/uart_mmio_slave_pkg.sv | 57 +++++
 rtl/uart_mmio_slave_tx_fifo.sv | 60 ++++++
 rtl/uart_mmio_slave.sv | 152 +++++++++++++++
 tb/tb_uart_mmio_slave.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_slave_pkg.sv
// Shared register map, bit positions and types for the memory-mapped UART slave.
package uart_mmio_slave_pkg;

    localparam int unsigned RX_W = 8;

    typedef enum logic [2:0] {
        OFS_TXDATA = 3'd0,
        OFS_RXDATA = 3'd1,
        OFS_STATUS = 3'd2,
        OFS_CTRL   = 3'd3,
        OFS_BAUD   = 3'd4,
        OFS_CLEAR  = 3'd5,
        OFS_RSVD6  = 3'd6,
        OFS_RSVD7  = 3'd7
    } reg_ofs_e;

    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_RX_FULL  = 2;
    localparam int unsigned ST_RX_OVR   = 3;
    localparam int unsigned ST_TX_BUSY  = 4;
    localparam int unsigned ST_TX_OVF   = 5;

    localparam int unsigned CTRL_TX_EN  = 0;
    localparam int unsigned CTRL_RX_EN  = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned CLR_RX_FULL = 0;
    localparam int unsigned CLR_RX_OVR  = 1;
    localparam int unsigned CLR_TX_OVF  = 2;

    typedef struct packed {
        logic irq_en;
        logic rx_en;
        logic tx_en;
    } ctrl_t;

    function automatic logic [5:0] pack_status(
        input logic tx_ovf,
        input logic tx_busy,
        input logic rx_ovr,
        input logic rx_full,
        input logic tx_empty,
        input logic tx_full
    );
        logic [5:0] s;
        s              = '0;
        s[ST_TX_OVF]   = tx_ovf;
        s[ST_TX_BUSY]  = tx_busy;
        s[ST_RX_OVR]   = rx_ovr;
        s[ST_RX_FULL]  = rx_full;
        s[ST_TX_EMPTY] = tx_empty;
        s[ST_TX_FULL]  = tx_full;
        return s;
    endfunction

endpackage

// File: rtl/uart_mmio_slave_tx_fifo.sv
// First-word fall-through byte FIFO feeding the UART serializer.
// Push while full and pop while empty are ignored; full/empty reflect pre-edge state.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_slave.sv
// Memory-mapped UART register slave: decode, TX FIFO, CTRL/BAUD, RX holding, read mux.
// Optional UART_IRQ_EN enables the registered interrupt and CTRL.irq_en bit.
module uart_mmio_slave
    import uart_mmio_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned TX_DEPTH         = 4,
    parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd434
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  HSel,
    input  logic                  WSel,
    input  logic [31:0]           map_Address,
    input  logic [DATA_WIDTH-1:0] map_Data,
    output logic [DATA_WIDTH-1:0] HRData,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic                  tx_busy,
    input  logic [7:0]            rx_data,
    input  logic                  rx_strobe,
    output logic [15:0]           baud_div,
    output logic                  irq
);

    reg_ofs_e        ofs;
    logic            wr;
    logic            wr_txdata;
    logic            wr_ctrl;
    logic            wr_baud;
    logic            wr_clear;
    logic            tx_full;
    logic            tx_empty;
    logic            tx_pop;
    logic            tx_ovf;
    logic            rx_full;
    logic            rx_ovr;
    logic [RX_W-1:0] rx_hold;
    logic            rx_take;
    logic            clr_rx_full;
    ctrl_t           ctrl_q;
    logic [15:0]     baud_q;
    logic [DATA_WIDTH-1:0] rdata;
    logic            unused_bits;

    assign unused_bits = ^{map_Address[31:3], map_Data[DATA_WIDTH-1:16]};

    assign ofs       = reg_ofs_e'(map_Address[2:0]);
    assign wr        = HSel & WSel;
    assign wr_txdata = wr & (ofs == OFS_TXDATA);
    assign wr_ctrl   = wr & (ofs == OFS_CTRL);
    assign wr_baud   = wr & (ofs == OFS_BAUD);
    assign wr_clear  = wr & (ofs == OFS_CLEAR);

    assign tx_valid  = ctrl_q.tx_en & ~tx_empty;
    assign tx_pop    = tx_valid & tx_ready;
    assign baud_div  = baud_q;

    uart_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_txdata),
        .pop   (tx_pop),
        .din   (map_Data[7:0]),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
            baud_q <= DEFAULT_BAUD_DIV;
        end else begin
            if (wr_ctrl) begin
                ctrl_q.tx_en  <= map_Data[CTRL_TX_EN];
                ctrl_q.rx_en  <= map_Data[CTRL_RX_EN];
`ifdef UART_IRQ_EN
                ctrl_q.irq_en <= map_Data[CTRL_IRQ_EN];
`else
                ctrl_q.irq_en <= 1'b0;
`endif
            end
            if (wr_baud) begin
                baud_q <= map_Data[15:0];
            end
        end
    end

    assign rx_take     = rx_strobe & ctrl_q.rx_en;
    assign clr_rx_full = wr_clear & map_Data[CLR_RX_FULL];

    // A new byte beats a same-cycle clear; an explicit clear masks the overrun it would cause.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_hold <= '0;
            rx_full <= 1'b0;
            rx_ovr  <= 1'b0;
            tx_ovf  <= 1'b0;
        end else begin
            if (rx_take) begin
                rx_hold <= rx_data;
                rx_full <= 1'b1;
            end else if (clr_rx_full) begin
                rx_full <= 1'b0;
            end
            if (rx_take && rx_full && !clr_rx_full) begin
                rx_ovr <= 1'b1;
            end else if (wr_clear && map_Data[CLR_RX_OVR]) begin
                rx_ovr <= 1'b0;
            end
            if (wr_txdata && tx_full) begin
                tx_ovf <= 1'b1;
            end else if (wr_clear && map_Data[CLR_TX_OVF]) begin
                tx_ovf <= 1'b0;
            end
        end
    end

`ifdef UART_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= ctrl_q.irq_en & (rx_full | tx_empty);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (HSel) begin
            case (ofs)
                OFS_RXDATA: rdata[RX_W-1:0] = rx_hold;
                OFS_STATUS: rdata[5:0]      = pack_status(tx_ovf, tx_busy, rx_ovr,
                                                          rx_full, tx_empty, tx_full);
                OFS_CTRL:   rdata[2:0]      = ctrl_q;
                OFS_BAUD:   rdata[15:0]     = baud_q;
                default:    rdata           = '0;
            endcase
        end
    end

    assign HRData = rdata;

endmodule

// File: tb/tb_uart_mmio_slave.sv
// Self-checking bench for uart_mmio_slave: vector table, directed corner sequences
// and a randomized run against a queue-based register model.
module tb_uart_mmio_slave;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        HSel;
    logic        WSel;
    logic [31:0] map_Address;
    logic [31:0] map_Data;
    logic [31:0] HRData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_strobe;
    logic [15:0] baud_div;
    logic        irq;

    int checks = 0;
    int errors = 0;

    uart_mmio_slave #(
        .DATA_WIDTH       (32),
        .TX_DEPTH         (DEPTH),
        .DEFAULT_BAUD_DIV (16'd434)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .HSel        (HSel),
        .WSel        (WSel),
        .map_Address (map_Address),
        .map_Data    (map_Data),
        .HRData      (HRData),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .rx_data     (rx_data),
        .rx_strobe   (rx_strobe),
        .baud_div    (baud_div),
        .irq         (irq)
    );

    always #5 clk = ~clk;

`ifdef UART_IRQ_EN
    localparam logic [2:0] CTRL_MASK = 3'b111;
`else
    localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

    // Reference model state
    logic [7:0]  q[$];
    logic [2:0]  ctrl_m;
    logic [15:0] baud_m;
    logic [7:0]  rx_hold_m;
    logic        rx_full_m, rx_ovr_m, tx_ovf_m, irq_m;

    typedef struct {
        bit          wr;
        logic [2:0]  ofs;
        logic [31:0] val;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] ofs, input logic [31:0] data);
        @(negedge clk);
        HSel = 1'b1;
        WSel = 1'b1;
        map_Address = {29'd0, ofs};
        map_Data = data;
        @(posedge clk);
        #1;
        HSel = 1'b0;
        WSel = 1'b0;
    endtask

    task automatic read_check(input logic [2:0] ofs, input logic [31:0] exp, input string name);
        @(negedge clk);
        HSel = 1'b1;
        WSel = 1'b0;
        map_Address = {29'd0, ofs};
        #1;
        check(name, HRData, exp);
        HSel = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(negedge clk);
        rx_strobe = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1;
        rx_strobe = 1'b0;
    endtask

    task automatic pop_one(input logic [7:0] exp, input string name);
        @(negedge clk);
        #1;
        check({name, "_valid"}, {31'd0, tx_valid}, 32'd1);
        check({name, "_data"}, {24'd0, tx_data}, {24'd0, exp});
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] o);
        case (o)
            3'd1:    return {24'd0, rx_hold_m};
            3'd2:    return {26'd0, tx_ovf_m, tx_busy, rx_ovr_m, rx_full_m,
                             (q.size() == 0), (q.size() == DEPTH)};
            3'd3:    return {29'd0, ctrl_m};
            3'd4:    return {16'd0, baud_m};
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        HSel = 1'b0; WSel = 1'b0; map_Address = '0; map_Data = '0;
        tx_ready = 1'b0; tx_busy = 1'b0; rx_data = '0; rx_strobe = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state and plain register access
        #1;
        check("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("reset_hrdata_unselected", HRData, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_baud_div", {16'd0, baud_div}, 32'd434);

        vecs.push_back('{0, 3'd2, 32'h02, "rst_status"});
        vecs.push_back('{0, 3'd4, 32'd434, "rst_baud"});
        vecs.push_back('{0, 3'd3, 32'h0, "rst_ctrl"});
        vecs.push_back('{0, 3'd1, 32'h0, "rst_rxdata"});
        vecs.push_back('{0, 3'd0, 32'h0, "txdata_reads0"});
        vecs.push_back('{1, 3'd4, 32'hDEAD1234, "wr_baud"});
        vecs.push_back('{0, 3'd4, 32'h1234, "baud_rb"});
        vecs.push_back('{1, 3'd4, 32'd434, "wr_baud_back"});
        vecs.push_back('{1, 3'd3, 32'hFF, "wr_ctrl_ff"});
        vecs.push_back('{0, 3'd3, {29'd0, CTRL_MASK}, "ctrl_rb"});
        vecs.push_back('{1, 3'd3, 32'h0, "wr_ctrl_0"});
        vecs.push_back('{1, 3'd6, 32'hFFFF_FFFF, "wr_rsvd6"});
        vecs.push_back('{0, 3'd6, 32'h0, "rsvd6_rb"});
        vecs.push_back('{0, 3'd7, 32'h0, "rsvd7_rb"});
        vecs.push_back('{0, 3'd5, 32'h0, "clear_reads0"});
        vecs.push_back('{0, 3'd2, 32'h02, "status_after_rsvd"});
        foreach (vecs[i]) begin
            if (vecs[i].wr) bus_write(vecs[i].ofs, vecs[i].val);
            else            read_check(vecs[i].ofs, vecs[i].val, vecs[i].name);
        end

        // Basic transmit with fall-through head
        bus_write(3'd3, 32'h1);
        bus_write(3'd0, 32'h41);
        bus_write(3'd0, 32'h42);
        read_check(3'd2, 32'h00, "t2_status_two");
        pop_one(8'h41, "t2_pop0");
        pop_one(8'h42, "t2_pop1");
        read_check(3'd2, 32'h02, "t2_status_empty");
        check("t2_valid_low", {31'd0, tx_valid}, 32'd0);

        // Overflow: fifth byte dropped
        for (int i = 0; i < 5; i++) bus_write(3'd0, 32'h10 + i);
        read_check(3'd2, 32'h21, "t3_status_full_ovf");
        bus_write(3'd5, 32'h4);
        read_check(3'd2, 32'h01, "t3_status_ovf_clr");
        for (int i = 0; i < 4; i++) pop_one(8'h10 + 8'(i), "t3_drain");
        read_check(3'd2, 32'h02, "t3_status_drained");

        // Full FIFO: a same-cycle pop does not make room for a push
        for (int i = 0; i < 4; i++) bus_write(3'd0, 32'h20 + i);
        @(negedge clk);
        HSel = 1'b1; WSel = 1'b1; map_Address = 32'd0; map_Data = 32'h24; tx_ready = 1'b1;
        @(posedge clk);
        #1;
        HSel = 1'b0; WSel = 1'b0; tx_ready = 1'b0;
        read_check(3'd2, 32'h20, "full_pushpop_status");
        for (int i = 1; i < 4; i++) pop_one(8'h20 + 8'(i), "full_pushpop_drain");
        read_check(3'd2, 32'h22, "full_pushpop_empty");
        bus_write(3'd5, 32'h4);

        // tx_en low holds tx_valid but keeps contents
        bus_write(3'd0, 32'h5A);
        bus_write(3'd3, 32'h0);
        @(negedge clk);
        tx_ready = 1'b1;
        #1;
        check("txen0_valid_low", {31'd0, tx_valid}, 32'd0);
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        read_check(3'd2, 32'h00, "txen0_retained");
        bus_write(3'd3, 32'h1);
        pop_one(8'h5A, "txen1_pop");

        // RX overrun and clear
        bus_write(3'd3, 32'h2);
        rx_pulse(8'h55);
        rx_pulse(8'hAA);
        read_check(3'd1, 32'hAA, "t4_rxdata");
        read_check(3'd2, 32'h0E, "t4_status_ovr");
        bus_write(3'd5, 32'h3);
        read_check(3'd2, 32'h02, "t4_status_clr");

        // Clear and strobe in the same cycle: the new byte wins
        @(negedge clk);
        HSel = 1'b1; WSel = 1'b1; map_Address = 32'd5; map_Data = 32'h1;
        rx_strobe = 1'b1; rx_data = 8'h33;
        @(posedge clk);
        #1;
        HSel = 1'b0; WSel = 1'b0; rx_strobe = 1'b0;
        read_check(3'd2, 32'h06, "t5_status");
        read_check(3'd1, 32'h33, "t5_rxdata");
        bus_write(3'd3, 32'h0);
        rx_pulse(8'h77);
        read_check(3'd1, 32'h33, "rxen0_ignored");
        read_check(3'd2, 32'h06, "rxen0_no_ovr");
        bus_write(3'd5, 32'h1);

        // Interrupt and reset during a pop
`ifdef UART_IRQ_EN
        bus_write(3'd3, 32'h7);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("t6_irq_set", {31'd0, irq}, 32'd1);
`else
        bus_write(3'd3, 32'h7);
        check("irq_tied_low", {31'd0, irq}, 32'd0);
`endif
        for (int i = 0; i < 3; i++) bus_write(3'd0, 32'h60 + i);
        @(negedge clk);
        tx_ready = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid_async", {31'd0, tx_valid}, 32'd0);
        check("t6_rst_irq_async", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tx_ready = 1'b0;
        read_check(3'd2, 32'h02, "t6_status_after_rst");
        read_check(3'd3, 32'h0, "t6_ctrl_after_rst");
        read_check(3'd4, 32'd434, "t6_baud_after_rst");

        // Randomized run against the model
        do_reset();
        q.delete();
        ctrl_m = '0; baud_m = 16'd434; rx_hold_m = '0;
        rx_full_m = 0; rx_ovr_m = 0; tx_ovf_m = 0; irq_m = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [2:0]  o;
            logic [31:0] a;
            logic        wr, emp, full, take, clr_full;
            @(negedge clk);
            o = 3'($urandom_range(0, 7));
            a = $urandom();
            a[2:0] = o;
            HSel = ($urandom_range(0, 3) != 0);
            WSel = ($urandom_range(0, 2) == 0);
            map_Address = a;
            map_Data = $urandom();
            if (o == 3'd3 && $urandom_range(0, 3) != 0) map_Data[1:0] = 2'b11;
            tx_ready = $urandom_range(0, 1);
            tx_busy = $urandom_range(0, 1);
            rx_strobe = ($urandom_range(0, 3) == 0);
            rx_data = 8'($urandom());
            #1;
            check("rnd_hrdata", HRData, HSel ? model_read(o) : 32'd0);
            check("rnd_tx_valid", {31'd0, tx_valid}, {31'd0, (ctrl_m[0] && q.size() > 0)});
            if (ctrl_m[0] && q.size() > 0)
                check("rnd_tx_data", {24'd0, tx_data}, {24'd0, q[0]});
            check("rnd_baud_div", {16'd0, baud_div}, {16'd0, baud_m});
            check("rnd_irq", {31'd0, irq}, {31'd0, irq_m});

            wr = HSel && WSel;
            emp = (q.size() == 0);
            full = (q.size() == DEPTH);
            irq_m = ctrl_m[2] && (rx_full_m || emp);
            take = rx_strobe && ctrl_m[1];
            clr_full = wr && o == 3'd5 && map_Data[0];
            if (ctrl_m[0] && !emp && tx_ready) void'(q.pop_front());
            if (wr && o == 3'd0) begin
                if (full) tx_ovf_m = 1'b1;
                else q.push_back(map_Data[7:0]);
            end
            if (take && rx_full_m && !clr_full) rx_ovr_m = 1'b1;
            else if (wr && o == 3'd5 && map_Data[1]) rx_ovr_m = 1'b0;
            if (take) begin
                rx_hold_m = rx_data;
                rx_full_m = 1'b1;
            end else if (clr_full) begin
                rx_full_m = 1'b0;
            end
            if (wr && o == 3'd5 && map_Data[2]) tx_ovf_m = 1'b0;
            if (wr && o == 3'd3) ctrl_m = map_Data[2:0] & CTRL_MASK;
            if (wr && o == 3'd4) baud_m = map_Data[15:0];
            @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
